// File: rtl/axi4_lite_pkg.sv
// AXI4-Lite response codes and handshake FSM encodings shared by subordinate and master.
// Pure constants: no latency, no flow control.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_COLLECT = 2'd1;
  localparam logic [1:0] W_RESP    = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Register storage with byte-strobe merge, combinational read mux and flat parallel output.
// Writes land on the clock edge of i_wr_en; no backpressure, the caller gates i_wr_en.
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_wr_en,
  input  logic [IDX_W-1:0]               i_wr_idx,
  input  logic [DATA_WIDTH-1:0]          i_wr_data,
  input  logic [DATA_WIDTH/8-1:0]        i_wr_strb,
  input  logic [IDX_W-1:0]               i_rd_idx,
  output logic [DATA_WIDTH-1:0]          o_rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_wr_strb[b]) r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
      end
    end
  end

  // Combinational read sees the pre-commit value when a read and write coincide.
  assign o_rd_data = r_mem[i_rd_idx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
  end

endmodule

// File: rtl/axi4_lite_s_regfile.sv
// AXI4-Lite subordinate onto a register bank; AW+W same cycle -> BVALID next cycle, AR -> RVALID next cycle.
// READY drops while a response is pending or an AW/W beat is held; VALID never depends on READY.
module axi4_lite_s_regfile
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int ADDR_LSB = $clog2(DATA_WIDTH/8);
  localparam logic [IDX_W:0] LP_NUM_REGS = NUM_REGS[IDX_W:0];

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axi4_lite_s_regfile: DATA_WIDTH must be 32 or 64");
  end
  if (ADDR_WIDTH < ADDR_LSB + IDX_W || NUM_REGS < 2) begin : g_bad_geometry
    $error("axi4_lite_s_regfile: ADDR_WIDTH too small or NUM_REGS < 2");
  end

  function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [IDX_W:0] v_idx;
    v_idx = {1'b0, a[ADDR_LSB +: IDX_W]};
    return ((a >> (ADDR_LSB + IDX_W)) == '0) && (v_idx < LP_NUM_REGS);
  endfunction

  logic [1:0]              r_w_state;
  logic                    r_aw_held, r_w_held;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic [1:0]              r_bresp;
  logic [0:0]              r_r_state;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;

  logic                    w_bvalid, w_rvalid, w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_ok;
  logic [ADDR_WIDTH-1:0]   w_waddr;
  logic [DATA_WIDTH-1:0]   w_wdata, w_bank_rd;
  logic [DATA_WIDTH/8-1:0] w_wstrb;
  logic                    w_unused;

  assign w_bvalid = (r_w_state == W_RESP);
  assign w_rvalid = (r_r_state == R_DATA);
  assign AWREADY  = ~r_aw_held & ~w_bvalid & ~ARESET;
  assign WREADY   = ~r_w_held & ~w_bvalid & ~ARESET;
  assign ARREADY  = ~w_rvalid & ~ARESET;
  assign w_aw_hs  = AWVALID & AWREADY;
  assign w_w_hs   = WVALID & WREADY;
  assign w_ar_hs  = ARVALID & ARREADY;

  // A beat still handshaking this cycle is forwarded so AW+W together commit without a bubble.
  assign w_waddr  = r_aw_held ? r_awaddr : AWADDR;
  assign w_wdata  = r_w_held ? r_wdata : WDATA;
  assign w_wstrb  = r_w_held ? r_wstrb : WSTRB;
  assign w_commit = ~w_bvalid & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
  assign w_wr_ok  = f_in_range(w_waddr);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_w_state <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= WDATA;
        r_wstrb  <= WSTRB;
      end
      case (r_w_state)
        W_IDLE, W_COLLECT: begin
          if (w_commit) begin
            r_w_state <= W_RESP;
            r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
          end else if (w_aw_hs | w_w_hs) begin
            r_w_state <= W_COLLECT;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_w_state <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
          end
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_r_state <= R_IDLE;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_r_state <= R_DATA;
      r_rdata   <= f_in_range(ARADDR) ? w_bank_rd : '0;
      r_rresp   <= f_in_range(ARADDR) ? RESP_OKAY : RESP_SLVERR;
    end else if (w_rvalid && RREADY) begin
      r_r_state <= R_IDLE;
    end
  end

  axi4_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_bank (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_wr_en   (w_commit & w_wr_ok),
    .i_wr_idx  (w_waddr[ADDR_LSB +: IDX_W]),
    .i_wr_data (w_wdata),
    .i_wr_strb (w_wstrb),
    .i_rd_idx  (ARADDR[ADDR_LSB +: IDX_W]),
    .o_rd_data (w_bank_rd),
    .o_regs    (regs_o)
  );

  assign BVALID   = w_bvalid;
  assign BRESP    = r_bresp;
  assign RVALID   = w_rvalid;
  assign RDATA    = r_rdata;
  assign RRESP    = r_rresp;
  assign w_unused = &{1'b0, AWPROT, ARPROT};

endmodule

// File: tb/tb_axi4_lite_s_regfile.sv
// Directed bench for axi4_lite_s_regfile with hand-computed expectations.
module tb_axi4_lite_s_regfile;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [31:0]  AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic [2:0]   AWPROT = '0, ARPROT = '0;
  logic [3:0]   WSTRB = '0;
  logic         AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
  logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]   BRESP, RRESP;
  logic [31:0]  RDATA;
  logic [511:0] regs_o;

  int n_pass = 0;
  int n_total = 0;

  axi4_lite_s_regfile dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .regs_o(regs_o)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] reg_at(input int i);
    return regs_o[i*32 +: 32];
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, aw_now, w_now;
    int n;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 0;
    aw_done = 0; w_done = 0; n = 0; ok = 0; resp = 2'b11;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = AWVALID && AWREADY;
      w_now  = WVALID && WREADY;
      tick(); n++;
      if (aw_now) begin AWVALID = 0; aw_done = 1; end
      if (w_now) begin WVALID = 0; w_done = 1; end
    end
    n = 0;
    while (!BVALID && n < 20) begin tick(); n++; end
    if (aw_done && w_done && BVALID) begin
      resp = BRESP; ok = 1; BREADY = 1; tick(); BREADY = 0;
    end
    AWVALID = 0; WVALID = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output bit ok);
    int n;
    bit ar_now;
    ARADDR = a; ARVALID = 1; RREADY = 0; n = 0; ok = 0; d = 'x; resp = 2'b11; ar_now = 0;
    while (!ar_now && n < 20) begin
      ar_now = ARVALID && ARREADY;
      tick(); n++;
    end
    ARVALID = 0;
    n = 0;
    while (!RVALID && n < 20) begin tick(); n++; end
    if (ar_now && RVALID) begin
      d = RDATA; resp = RRESP; ok = 1; RREADY = 1; tick(); RREADY = 0;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_total++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0)
      $display("FAIL rst_hs: got %b want 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    else n_pass++;
    n_total++;
    if (regs_o !== '0 || RDATA !== 32'h0 || BRESP !== 2'b00 || RRESP !== 2'b00)
      $display("FAIL rst_vals: regs_o nonzero=%0b RDATA=%h BRESP=%b RRESP=%b",
               regs_o != '0, RDATA, BRESP, RRESP);
    else n_pass++;
    ARESET = 0; #1;
    n_total++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111)
      $display("FAIL rst_release_rdy: got %b want 111", {AWREADY, WREADY, ARREADY});
    else n_pass++;
    // Hold an AW beat, then reset before the W beat arrives.
    AWADDR = 32'h0; AWVALID = 1; tick(); AWVALID = 0;
    n_total++;
    if (AWREADY !== 1'b0) $display("FAIL rst_aw_held: AWREADY got %b want 0", AWREADY);
    else n_pass++;
    ARESET = 1; #1;
    n_total++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0)
      $display("FAIL rst_mid_hs: got %b want 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    else n_pass++;
    repeat (2) tick();
    ARESET = 0; tick();
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1; tick(); WVALID = 0;
    repeat (3) tick();
    n_total++;
    if (BVALID !== 1'b0 || regs_o !== '0)
      $display("FAIL rst_no_write: BVALID got %b want 0, reg0 got %h want 0", BVALID, reg_at(0));
    else n_pass++;
    ARESET = 1; tick(); ARESET = 0; tick();
    n_total++;
    if ({AWREADY, WREADY} !== 2'b11) $display("FAIL rst_clear: rdy got %b want 11", {AWREADY, WREADY});
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    AWADDR = 32'h8; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    n_total++;
    if ({AWREADY, WREADY} !== 2'b11) $display("FAIL sc_rdy: got %b want 11", {AWREADY, WREADY});
    else n_pass++;
    tick(); AWVALID = 0; WVALID = 0;
    n_total++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00)
      $display("FAIL sc_b: BVALID got %b want 1, BRESP got %b want 00", BVALID, BRESP);
    else n_pass++;
    n_total++;
    if (reg_at(2) !== 32'hDEADBEEF) $display("FAIL sc_reg2: got %h want deadbeef", reg_at(2));
    else n_pass++;
    BREADY = 1; tick(); BREADY = 0;
    n_total++;
    if (BVALID !== 1'b0) $display("FAIL sc_b_drop: BVALID got %b want 0", BVALID);
    else n_pass++;
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp;
    bit ok;
    int extra_b;
    do_write(32'h4, 32'hFFFFFFFF, 4'hF, resp, ok);
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1; tick(); WVALID = 0;
    tick(); tick();
    n_total++;
    if (BVALID !== 1'b0 || WREADY !== 1'b0 || AWREADY !== 1'b1)
      $display("FAIL wfirst_wait: BVALID=%b WREADY=%b AWREADY=%b want 0 0 1", BVALID, WREADY, AWREADY);
    else n_pass++;
    AWADDR = 32'h4; AWVALID = 1; tick(); AWVALID = 0;
    n_total++;
    if (BVALID !== 1'b1 || reg_at(1) !== 32'hFF22FF44)
      $display("FAIL wfirst_merge: BVALID got %b want 1, reg1 got %h want ff22ff44", BVALID, reg_at(1));
    else n_pass++;
    BREADY = 1; tick(); BREADY = 0;
    extra_b = 0;
    repeat (3) begin if (BVALID) extra_b++; tick(); end
    n_total++;
    if (extra_b !== 0) $display("FAIL wfirst_one_b: extra B cycles got %0d want 0", extra_b);
    else n_pass++;
  endtask

  task automatic test_bp();
    logic [1:0] resp;
    bit ok;
    int bad;
    AWADDR = 32'hC; WDATA = 32'hCAFE0001; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    tick();
    // Keep the master offering a new write while B is stalled; it must not be accepted.
    AWADDR = 32'h10; WDATA = 32'h0BADF00D;
    bad = 0;
    repeat (5) begin
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || WREADY !== 1'b0) bad++;
      tick();
    end
    AWVALID = 0; WVALID = 0;
    n_total++;
    if (bad !== 0) $display("FAIL bp_stable: bad cycles got %0d want 0", bad);
    else n_pass++;
    n_total++;
    if (reg_at(4) !== 32'h0) $display("FAIL bp_no_accept: reg4 got %h want 0", reg_at(4));
    else n_pass++;
    BREADY = 1; tick(); BREADY = 0;
    do_write(32'h10, 32'h0BADF00D, 4'hF, resp, ok);
    n_total++;
    if (!ok || resp !== 2'b00 || reg_at(4) !== 32'h0BADF00D || reg_at(3) !== 32'hCAFE0001)
      $display("FAIL bp_second: ok=%0b resp=%b reg4=%h reg3=%h want 1 00 0badf00d cafe0001",
               ok, resp, reg_at(4), reg_at(3));
    else n_pass++;
  endtask

  task automatic test_oob();
    logic [31:0] d;
    logic [1:0] resp;
    logic [511:0] snap;
    bit ok;
    do_read(32'h40, d, resp, ok);
    n_total++;
    if (!ok || resp !== 2'b10 || d !== 32'h0)
      $display("FAIL oob_read: ok=%0b resp=%b data=%h want 1 10 0", ok, resp, d);
    else n_pass++;
    snap = regs_o;
    do_write(32'h40, 32'h55AA55AA, 4'hF, resp, ok);
    n_total++;
    if (!ok || resp !== 2'b10 || regs_o !== snap)
      $display("FAIL oob_write: ok=%0b resp=%b regs_changed=%0b want 1 10 0", ok, resp, regs_o !== snap);
    else n_pass++;
    do_write(32'h1000_0008, 32'h55AA55AA, 4'hF, resp, ok);
    n_total++;
    if (!ok || resp !== 2'b10 || reg_at(2) !== 32'hDEADBEEF)
      $display("FAIL oob_hibit: ok=%0b resp=%b reg2=%h want 1 10 deadbeef", ok, resp, reg_at(2));
    else n_pass++;
    do_read(32'hA, d, resp, ok);
    n_total++;
    if (!ok || resp !== 2'b00 || d !== 32'hDEADBEEF)
      $display("FAIL lsb_ignored: ok=%0b resp=%b data=%h want 1 00 deadbeef", ok, resp, d);
    else n_pass++;
  endtask

  task automatic test_rw_same();
    logic [31:0] d;
    logic [1:0] resp;
    bit ok;
    int bad;
    do_write(32'hC, 32'h5, 4'hF, resp, ok);
    AWADDR = 32'hC; WDATA = 32'hA; WSTRB = 4'hF; ARADDR = 32'hC;
    AWVALID = 1; WVALID = 1; ARVALID = 1; BREADY = 0; RREADY = 0;
    tick(); AWVALID = 0; WVALID = 0; ARVALID = 0;
    n_total++;
    if (RVALID !== 1'b1 || RDATA !== 32'h5 || RRESP !== 2'b00)
      $display("FAIL rw_old: RVALID=%b RDATA=%h RRESP=%b want 1 00000005 00", RVALID, RDATA, RRESP);
    else n_pass++;
    n_total++;
    if (BVALID !== 1'b1 || reg_at(3) !== 32'hA)
      $display("FAIL rw_commit: BVALID=%b reg3=%h want 1 0000000a", BVALID, reg_at(3));
    else n_pass++;
    bad = 0;
    repeat (4) begin
      if (RVALID !== 1'b1 || RDATA !== 32'h5 || ARREADY !== 1'b0) bad++;
      tick();
    end
    n_total++;
    if (bad !== 0) $display("FAIL rw_r_stall: bad cycles got %0d want 0", bad);
    else n_pass++;
    RREADY = 1; BREADY = 1; tick(); RREADY = 0; BREADY = 0;
    n_total++;
    if (RVALID !== 1'b0 || BVALID !== 1'b0)
      $display("FAIL rw_drop: RVALID=%b BVALID=%b want 0 0", RVALID, BVALID);
    else n_pass++;
    do_read(32'hC, d, resp, ok);
    n_total++;
    if (!ok || d !== 32'hA) $display("FAIL rw_reread: ok=%0b data=%h want 1 0000000a", ok, d);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    AWADDR = 32'h14; WDATA = 32'h1; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
    tick();
    AWADDR = 32'h18; WDATA = 32'h2;
    n_total++;
    if (BVALID !== 1'b1 || AWREADY !== 1'b0)
      $display("FAIL b2b_first: BVALID=%b AWREADY=%b want 1 0", BVALID, AWREADY);
    else n_pass++;
    tick();
    n_total++;
    if ({AWREADY, WREADY, BVALID} !== 3'b110)
      $display("FAIL b2b_reopen: AWREADY WREADY BVALID got %b want 110", {AWREADY, WREADY, BVALID});
    else n_pass++;
    tick(); AWVALID = 0; WVALID = 0;
    n_total++;
    if (BVALID !== 1'b1 || reg_at(5) !== 32'h1 || reg_at(6) !== 32'h2)
      $display("FAIL b2b_regs: BVALID=%b reg5=%h reg6=%h want 1 1 2", BVALID, reg_at(5), reg_at(6));
    else n_pass++;
    tick(); BREADY = 0;
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_bp();
    test_oob();
    test_rw_same();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
